// File: rtl/sram_port_arbiter.sv
// Shares one SRAM port between data and instruction-fetch requesters, round-robin.
// Latency: WAIT_CYCLES access cycles after accept, then one done cycle; one IDLE cycle between accesses.
// Backpressure: requests are levels held until done; requests are only sampled in IDLE.
module sram_port_arbiter #(
  parameter int          WAIT_CYCLES = 5,
  parameter logic [31:0] BASE_ADDR   = 32'd1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_done,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_done,
  output logic [31:0] rdata,
  output logic        busy,
  inout  wire  [31:0] SRAM_DQ,
  output logic [16:0] SRAM_ADDR,
  output logic        SRAM_WE_N
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  localparam logic [3:0] LAST_CNT = 4'(WAIT_CYCLES - 1);

  state_t      state;
  logic [3:0]  cnt;
  logic        ptr;        // favoured port: 0 = data, 1 = instruction
  logic        gnt;        // granted port:  0 = data, 1 = instruction
  logic        lat_we;
  logic [31:0] lat_wdata;
  logic        dq_oe;

  logic        d_wins;
  logic [31:0] sel_addr;

  always_comb begin
    d_wins   = d_req && (!i_req || !ptr);
    sel_addr = d_wins ? d_addr : i_addr;
  end

  assign SRAM_DQ = dq_oe ? lat_wdata : {32{1'bz}};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      ptr       <= 1'b0;
      gnt       <= 1'b0;
      lat_we    <= 1'b0;
      lat_wdata <= 32'd0;
      dq_oe     <= 1'b0;
      d_done    <= 1'b0;
      i_done    <= 1'b0;
      rdata     <= 32'd0;
      busy      <= 1'b0;
      SRAM_ADDR <= 17'd0;
      SRAM_WE_N <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (d_req || i_req) begin
            gnt       <= !d_wins;
            lat_we    <= d_wins && d_we;
            lat_wdata <= d_wdata;
            // Word address relative to the SRAM window; wraps, no range check.
            SRAM_ADDR <= 17'((sel_addr - BASE_ADDR) >> 2);
            SRAM_WE_N <= !(d_wins && d_we);
            dq_oe     <= d_wins && d_we;
            cnt       <= 4'd0;
            busy      <= 1'b1;
            state     <= ACCESS;
          end
        end
        ACCESS: begin
          cnt <= cnt + 4'd1;
          if (cnt == LAST_CNT) begin
            SRAM_WE_N <= 1'b1;
            dq_oe     <= 1'b0;
            if (!lat_we) rdata <= SRAM_DQ;
            d_done    <= !gnt;
            i_done    <= gnt;
            ptr       <= !gnt;
            state     <= DONE;
          end
        end
        DONE: begin
          d_done <= 1'b0;
          i_done <= 1'b0;
          busy   <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter with a behavioural SRAM and a completion scoreboard.
module tb_sram_port_arbiter;

  localparam int          W    = 5;
  localparam logic [31:0] BASE = 32'd1024;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        d_req, d_we, i_req;
  logic [31:0] d_addr, d_wdata, i_addr;
  logic        d_done, i_done, busy;
  logic [31:0] rdata;
  wire  [31:0] sram_dq;
  logic [16:0] sram_addr;
  logic        sram_we_n;

  sram_port_arbiter #(.WAIT_CYCLES(W), .BASE_ADDR(BASE)) dut (
    .clk(clk), .rst(rst),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_done(d_done),
    .i_req(i_req), .i_addr(i_addr), .i_done(i_done),
    .rdata(rdata), .busy(busy),
    .SRAM_DQ(sram_dq), .SRAM_ADDR(sram_addr), .SRAM_WE_N(sram_we_n)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // SRAM model: word i initialised to A5000000|i, drives the bus whenever not writing.
  logic [31:0] mem [0:255];
  logic        mem_init = 1'b0;
  assign sram_dq = sram_we_n ? mem[sram_addr[7:0]] : {32{1'bz}};
  always @(posedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'hA500_0000 | 32'(i);
      mem_init <= 1'b1;
    end else if (!sram_we_n) begin
      mem[sram_addr[7:0]] <= sram_dq;
    end
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    logic        port;   // 0 = data, 1 = instruction
    logic        rd;
    logic [31:0] dat;
    int          at;
  } exp_t;
  exp_t sbq[$];

  task automatic push(input logic port, input logic rd, input logic [31:0] dat, input int at);
    exp_t e;
    e.port = port; e.rd = rd; e.dat = dat; e.at = at;
    sbq.push_back(e);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst && (d_done || i_done)) begin
      chk("done_onehot", {31'd0, d_done & i_done}, 32'd0);
      if (sbq.size() == 0) begin
        chk("unexpected_done", {30'd0, d_done, i_done}, 32'd0);
      end else begin
        e = sbq.pop_front();
        chk("done_port", {31'd0, i_done}, {31'd0, e.port});
        chk("done_cyc", cyc, e.at);
        if (e.rd) chk("done_rdata", rdata, e.dat);
      end
    end
  end

  task automatic d_access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [16:0] exp_word, output int we_low);
    int n;
    n = 0; we_low = 0;
    d_we = we; d_addr = addr; d_wdata = wdata; d_req = 1'b1;
    do begin
      @(negedge clk);
      n++;
      if (!sram_we_n) begin
        we_low++;
        chk("wr_sram_addr", {15'd0, sram_addr}, {15'd0, exp_word});
        chk("wr_dq", sram_dq, wdata);
      end
    end while (!d_done && n < 100);
    chk("d_done_seen", {31'd0, d_done}, 32'd1);
    d_req = 1'b0;
  endtask

  task automatic i_access(input logic [31:0] addr, input int hold);
    int n;
    n = 0;
    i_addr = addr; i_req = 1'b1;
    do begin
      @(negedge clk);
      n++;
    end while (!i_done && n < 100);
    chk("i_done_seen", {31'd0, i_done}, 32'd1);
    repeat (hold) @(negedge clk);
    i_req = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int c, wl;
    d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0; i_req = 0; i_addr = 0;
    repeat (3) @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_we_n", {31'd0, sram_we_n}, 32'd1);
    chk("rst_sram_addr", {15'd0, sram_addr}, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_done", {30'd0, d_done, i_done}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Data write to 1032 -> word 2
    c = cyc;
    push(1'b0, 1'b0, 32'd0, c + 1 + W);
    d_access(1'b1, 32'd1032, 32'hDEADBEEF, 17'd2, wl);
    chk("wr_we_cycles", wl, W);
    chk("wr_mem", mem[2], 32'hDEADBEEF);

    // Read-back of 1032
    @(negedge clk);
    c = cyc;
    push(1'b0, 1'b1, 32'hDEADBEEF, c + 1 + W);
    d_access(1'b0, 32'd1032, 32'd0, 17'd2, wl);
    chk("rd_we_cycles", wl, 0);
    repeat (3) @(negedge clk);
    chk("rdata_hold", rdata, 32'hDEADBEEF);

    // A write must leave rdata untouched
    c = cyc;
    push(1'b0, 1'b0, 32'd0, c + 1 + W);
    d_access(1'b1, 32'd1036, 32'h11112222, 17'd3, wl);
    chk("wr2_we_cycles", wl, W);
    chk("rdata_after_wr", rdata, 32'hDEADBEEF);
    chk("wr2_mem", mem[3], 32'h11112222);

    // Simultaneous first requests after reset: data first, instruction 13 cycles after accept
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    c = cyc;
    push(1'b0, 1'b1, 32'hDEADBEEF, c + 1 + W);
    push(1'b1, 1'b1, 32'hA500_0001, c + 1 + 2 * W + 2);
    fork
      d_access(1'b0, 32'd1032, 32'd0, 17'd2, wl);
      i_access(32'd1028, 0);
    join

    // Continuous requests from both ports: D, I, D, I
    @(negedge clk);
    c = cyc;
    push(1'b0, 1'b1, 32'hDEADBEEF, c + 6);
    push(1'b1, 1'b1, 32'hA500_0004, c + 13);
    push(1'b0, 1'b1, 32'h11112222, c + 20);
    push(1'b1, 1'b1, 32'hA500_0005, c + 27);
    fork
      begin
        d_access(1'b0, 32'd1032, 32'd0, 17'd2, wl);
        d_access(1'b0, 32'd1036, 32'd0, 17'd3, wl);
      end
      begin
        i_access(32'd1040, 0);
        i_access(32'd1044, 0);
      end
    join

    // Reset in the 3rd ACCESS cycle of a write
    @(negedge clk);
    d_we = 1'b1; d_addr = 32'd1048; d_wdata = 32'h12345678; d_req = 1'b1;
    repeat (3) @(negedge clk);
    chk("abort_we_low", {31'd0, sram_we_n}, 32'd0);
    chk("abort_busy_pre", {31'd0, busy}, 32'd1);
    rst = 1'b1; d_req = 1'b0;
    #1;
    chk("abort_we_n", {31'd0, sram_we_n}, 32'd1);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_sram_addr", {15'd0, sram_addr}, 32'd0);
    chk("abort_dq", sram_dq, mem[0]);
    @(negedge clk); rst = 1'b0;
    repeat (3) @(negedge clk);
    c = cyc;
    push(1'b0, 1'b1, 32'hDEADBEEF, c + 1 + W);
    push(1'b1, 1'b1, 32'hA500_0001, c + 1 + 2 * W + 2);
    fork
      d_access(1'b0, 32'd1032, 32'd0, 17'd2, wl);
      i_access(32'd1028, 0);
    join

    // Instruction read at 1024 with req held one cycle past i_done -> second read
    @(negedge clk);
    c = cyc;
    push(1'b1, 1'b1, 32'hA500_0000, c + 1 + W);
    push(1'b1, 1'b1, 32'hA500_0000, c + 1 + 2 * W + 2);
    fork
      i_access(32'd1024, 2);
      begin
        repeat (3) @(negedge clk);
        chk("i_sram_addr", {15'd0, sram_addr}, 32'd0);
        chk("i_we_n", {31'd0, sram_we_n}, 32'd1);
        chk("i_busy", {31'd0, busy}, 32'd1);
      end
    join
    repeat (8) @(negedge clk);
    chk("sb_empty", sbq.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sram_port_arbiter.md
# sram_port_arbiter

Two-port arbiter and access sequencer for the single off-chip SRAM. It sits below the data cache and an instruction-fetch refill path and shares one SRAM port between them. It grants one requester at a time with round-robin priority, drives the SRAM address, data and write-enable lines for a fixed number of wait cycles, captures read data, and returns a one-cycle completion pulse to the granted requester.

## Interface
Parameters:
- WAIT_CYCLES, 5: SRAM access length in clock cycles; legal range 1–15.
- BASE_ADDR, 1024: byte address that maps to SRAM word 0.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- d_req  in  1  data-port request; level, held until d_done.
- d_we  in  1  data-port write (1) or read (0); stable while d_req is high.
- d_addr  in  32  data-port byte address.
- d_wdata  in  32  data-port write data.
- d_done  out  1  one-cycle pulse: data-port access complete.
- i_req  in  1  instruction-port read request; level, held until i_done.
- i_addr  in  32  instruction-port byte address.
- i_done  out  1  one-cycle pulse: instruction-port access complete.
- rdata  out  32  read data of the last completed read; valid while a done pulse is high and held until the next read completes.
- busy  out  1  high in ACCESS and DONE.
- SRAM_DQ  inout  32  SRAM data bus.
- SRAM_ADDR  out  17  SRAM word address.
- SRAM_WE_N  out  1  SRAM write enable, active low.

## Operation
- FSM states: IDLE, ACCESS, DONE.
- IDLE:
  - Evaluate d_req and i_req.
  - If any request is high, latch the winner, its address, we (forced 0 for the instruction port) and wdata into internal registers, clear the counter, and go to ACCESS.
  - With no request, stay in IDLE.
- Arbitration:
  - A 1-bit priority pointer names the favoured port. Reset value: data port.
  - If only one port requests, that port wins.
  - If both request, the pointer's port wins.
  - On entry to DONE, the pointer moves to the port that was not served.
- ACCESS:
  - SRAM_ADDR = (latched_addr − BASE_ADDR)[18:2], using 32-bit wrap-around subtraction. Range is not checked.
  - On a write: SRAM_WE_N = 0 and SRAM_DQ driven with latched wdata for every ACCESS cycle.
  - On a read: SRAM_WE_N = 1 and SRAM_DQ at high impedance.
  - The counter increments each cycle. At the edge where counter = WAIT_CYCLES−1, go to DONE; on a read, SRAM_DQ is also captured into rdata at that edge.
- DONE:
  - d_done or i_done (the granted port only) = 1.
  - SRAM_WE_N = 1, SRAM_DQ at high impedance.
  - Unconditionally go to IDLE.
- Requester rule: deassert req at the edge that ends its done cycle. A req still high in the following IDLE cycle is treated as a new request.
- Request inputs are ignored outside IDLE.
- A write leaves rdata unchanged.
- Outside ACCESS: SRAM_ADDR holds its last value (0 after reset), SRAM_WE_N = 1, SRAM_DQ at high impedance.

## Timing
- Reset (asynchronous, any state, including mid-ACCESS):
  - State IDLE, counter 0, pointer = data port.
  - d_done = i_done = 0, rdata = 0, busy = 0.
  - SRAM_ADDR = 0, SRAM_WE_N = 1, SRAM_DQ at high impedance.
  - An aborted write is not retried; the requester must reissue it.
- Latency:
  - Request high in IDLE at edge E.
  - ACCESS occupies cycles E+1 .. E+WAIT_CYCLES.
  - The done pulse occupies the cycle after E+WAIT_CYCLES.
  - Total: WAIT_CYCLES+1 cycles from accept to done.
- Throughput: a minimum of WAIT_CYCLES+2 cycles per access, because one IDLE cycle is always inserted between accesses.
- Simultaneous requests: the loser waits exactly one full access plus one IDLE cycle, then is guaranteed the grant.
- With WAIT_CYCLES = 1, ACCESS lasts exactly one cycle.

## Test plan
- Data write, WAIT_CYCLES=5: d_req=1, d_we=1, d_addr=1032, d_wdata=0xDEADBEEF → SRAM_ADDR=2 with SRAM_WE_N=0 for exactly 5 cycles; d_done pulses in the 6th cycle after accept; i_done stays 0.
- Read-back: data read of 1032 with the SRAM model holding 0xDEADBEEF → SRAM_WE_N stays 1, DQ undriven by the block; rdata=0xDEADBEEF during the d_done cycle and afterwards.
- Simultaneous first requests after reset: d_req and i_req rise together → data port served first, then one IDLE cycle, then the instruction port; i_done arrives 13 cycles after the common accept edge.
- Both ports requesting continuously for 4 accesses → grant order D, I, D, I; never two consecutive grants to the same port.
- Reset asserted in the 3rd ACCESS cycle of a write → SRAM_WE_N=1, DQ at high impedance, busy=0 immediately; no done pulse; the next request after reset is served normally with data-port priority.
- Instruction read at i_addr=1024 with a request held one cycle past i_done → SRAM_ADDR=0, rdata valid at i_done; the extra held cycle starts a second read (documented requester-rule violation).
